// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM state type and width default for the serial adder
package serial_adder_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - single-bit full adder shared by every bit position of the serial adder
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial LSB-first adder with valid/ready handshakes; SERIAL_ADDER_SUB_EN adds a subtract port
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [CW-1:0]    cnt_q;
    logic             fa_s;
    logic             fa_co;
    logic             sub_eff;
    logic             last_bit;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    assign last_bit = (cnt_q == LAST_BIT);

    fa_cell u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready = ~rst;
                if (start_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1; the forced carry replaces cin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q     <= op_a;
                        b_q     <= op_b ^ {WIDTH{sub_eff}};
                        carry_q <= sub_eff | cin;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
                    carry_q <= fa_co;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_bit) begin
                        cout_q <= fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed self-checking bench for serial_adder_ctrl (WIDTH=8)
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         sub_v = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int total = 0;
    int fails = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .cin         (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub         (sub_v),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        int n;
        n = 0;
        while (!start_ready && n < 30) begin
            tick();
            n++;
        end
        chk("start_ready_before_accept", 32'(start_ready), 32'd1);
        op_a = a; op_b = b; cin = c; sub_v = s;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("start_ready_in_run", 32'(start_ready), 32'd0);
    endtask

    task automatic wait_result(input string tag, input int lat0, input logic [W-1:0] es, input logic ec);
        int n;
        n = lat0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd8);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
    endtask

    task automatic release_result(input logic [W-1:0] es, input logic ec);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("idle_res_valid", 32'(res_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_start_ready", 32'(start_ready), 32'd1);
        chk("idle_sum_held", 32'(sum), 32'(es));
        chk("idle_cout_held", 32'(cout), 32'(ec));
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_sum", 32'(sum), 32'h0);
        chk("rst_cout", 32'(cout), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_release_start_ready", 32'(start_ready), 32'h1);
        tick();

        // 0xFF + 0x01 -> 0x00 carry 1
        start_op(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_result("ff_01", 0, 8'h00, 1'b1);
        release_result(8'h00, 1'b1);

        // 0xA5 + 0x5A + 1 -> 0x100
        start_op(8'hA5, 8'h5A, 1'b1, 1'b0);
        wait_result("a5_5a", 0, 8'h00, 1'b1);
        release_result(8'h00, 1'b1);

        // 0x12 + 0x34 -> 0x46, then hold DONE for 5 cycles
        start_op(8'h12, 8'h34, 1'b0, 1'b0);
        wait_result("12_34", 0, 8'h46, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_res_valid", 32'(res_valid), 32'd1);
            chk("hold_sum", 32'(sum), 32'h46);
            chk("hold_cout", 32'(cout), 32'd0);
            chk("hold_start_ready", 32'(start_ready), 32'd0);
        end
        release_result(8'h46, 1'b0);

        // 0xFF + 0xFF + 1 -> 0x1FF
        start_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        wait_result("ff_ff", 0, 8'hFF, 1'b1);
        release_result(8'hFF, 1'b1);

        // start pulses during RUN and DONE must be ignored
        start_op(8'h10, 8'h20, 1'b0, 1'b0);
        tick(); tick();
        op_a = 8'hFF; op_b = 8'hFF; cin = 1'b1;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        wait_result("ignore_run", 3, 8'h30, 1'b0);
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        chk("ignore_done_valid", 32'(res_valid), 32'd1);
        chk("ignore_done_sum", 32'(sum), 32'h30);
        release_result(8'h30, 1'b0);

        // reset at RUN cycle 4 aborts the operation
        start_op(8'h55, 8'h22, 1'b0, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        chk("abort_sum", 32'(sum), 32'h0);
        chk("abort_cout", 32'(cout), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_start_ready", 32'(start_ready), 32'd1);
        start_op(8'h03, 8'h04, 1'b0, 1'b0);
        wait_result("03_04", 0, 8'h07, 1'b0);
        release_result(8'h07, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        start_op(8'h05, 8'h07, 1'b0, 1'b1);
        wait_result("sub_05_07", 0, 8'hFE, 1'b0);
        release_result(8'hFE, 1'b0);
        start_op(8'h07, 8'h05, 1'b0, 1'b1);
        wait_result("sub_07_05", 0, 8'h02, 1'b1);
        release_result(8'h02, 1'b1);
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start_valid  input  1  operand request valid.
REQ-005 start_ready  output  1  block can accept operands.
REQ-006 op_a  input  WIDTH  first operand.
REQ-007 op_b  input  WIDTH  second operand.
REQ-008 cin  input  1  carry-in for bit 0.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  consumer accepts result.
REQ-011 sum  output  WIDTH  registered result.
REQ-012 cout  output  1  registered carry out of the MSB.
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 The block SHALL compute op_a + op_b + cin bit-serially, LSB first, using one full-adder cell for one bit per clock.
REQ-015 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-016 IDLE: start_ready=1. start_valid=1 at an edge SHALL capture op_a, op_b, cin into shift/carry registers, clear the bit counter and enter RUN.
REQ-017 RUN: each edge SHALL add bit 0 of the A/B shift registers with the carry flop, shift the sum bit into the MSB of the sum shift register, shift A/B right, update the carry flop and increment the counter.
REQ-018 After the WIDTH-th RUN edge, the FSM SHALL enter DONE, with sum holding the full result and cout holding the final carry.
REQ-019 Latency: operands accepted at edge k SHALL give res_valid=1 after edge k+WIDTH.
REQ-020 DONE: res_valid=1, and sum and cout SHALL stay stable until an edge with res_ready=1, which moves the FSM to IDLE.
REQ-021 start_ready SHALL be 0 in RUN and DONE; start_valid in those states SHALL be ignored and SHALL NOT corrupt state.
REQ-022 No back-to-back bypass from DONE to RUN: the next accept SHALL occur no earlier than the edge after the return to IDLE.
REQ-023 The bit counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap within an operation.
REQ-024 sum and cout SHALL hold the last result in IDLE until the next accept.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, with sum=0, cout=0, res_valid=0, busy=0, counter=0 and carry=0; start_ready=1 once rst deasserts.
REQ-026 Reset during RUN or DONE SHALL abort the operation with no result delivered.

Configuration
REQ-027 With SERIAL_ADDER_SUB_EN defined: an extra input port sub (1 bit), captured at accept; sub=1 SHALL invert op_b and force the initial carry to 1 (cin ignored), so the result is op_a - op_b and cout=1 means no borrow.
REQ-028 Without SERIAL_ADDER_SUB_EN: no sub port, and the block performs addition only.

Structure
REQ-029 A shared package serial_adder_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE) and the WIDTH default constant.
REQ-030 One sub-module, fa_cell (sum/carry of a, b, cin), SHALL be instantiated once and used for every bit position.

Verification
REQ-031 WIDTH=8, 0xFF+0x01, cin=0 -> after 8 cycles res_valid=1, sum=0x00, cout=1.
REQ-032 0xA5+0x5A, cin=1 -> sum=0x00, cout=1; 0x12+0x34, cin=0 -> sum=0x46, cout=0.
REQ-033 Hold res_ready=0 for 5 cycles in DONE -> res_valid, sum and cout stay constant; start_ready=0 throughout.
REQ-034 Pulse start_valid with new operands during RUN -> ignored; the original result is returned unchanged.
REQ-035 Assert rst at RUN cycle 4 -> immediately IDLE, all outputs at reset values; a following 0x03+0x04 gives 0x07.
REQ-036 With SERIAL_ADDER_SUB_EN, 0x05-0x07 with sub=1 -> sum=0xFE, cout=0; 0x07-0x05 -> sum=0x02, cout=1.
